// File: rtl/sar_result_buffer_if.sv
// Handshake bundle between the SAR result buffer and its producer/consumer side.
// master = controller + I/O side, slave = the buffer itself.
interface sar_result_buffer_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 3
);
  logic [DATA_W-1:0] result;
  logic              valid;
  logic [1:0]        avg_sel;
  logic              rd_en;
  logic              ovf_clr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              empty;
  logic              full;
  logic [CNT_W-1:0]  count;
  logic              overflow;

  modport master (
    output result, valid, avg_sel, rd_en, ovf_clr,
    input  rd_data, rd_valid, empty, full, count, overflow
  );

  modport slave (
    input  result, valid, avg_sel, rd_en, ovf_clr,
    output rd_data, rd_valid, empty, full, count, overflow
  );
endinterface

// File: rtl/sar_result_buffer.sv
// Captures SAR conversions on rising valid, averages 1/2/4/8 of them, and queues
// the averages in a small FIFO drained through a registered read port.
module sar_result_buffer #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 3
) (
  input  logic clk,
  input  logic reset_in,
  sar_result_buffer_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int ACC_W = DATA_W + 3;

  logic              valid_prev_q, valid_prev_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [2:0]        n_q, n_d;
  logic [1:0]        win_sel_q, win_sel_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              overflow_q, overflow_d;

  logic              accept, win_done, push, pop, is_full, write_ok;
  logic [1:0]        cur_win;
  logic [ACC_W-1:0]  sum;
  logic [DATA_W-1:0] avg;

  always_comb begin
    accept   = bus.valid & ~valid_prev_q;
    // A new window latches avg_sel on its first sample; later changes wait.
    cur_win  = (n_q == 3'd0) ? bus.avg_sel : win_sel_q;
    sum      = acc_q + {3'b000, bus.result};
    win_done = ({1'b0, n_q} + 4'd1) == (4'd1 << cur_win);
    avg      = DATA_W'(sum >> cur_win);
    push     = accept & win_done;
    is_full  = count_q == CNT_W'(DEPTH);
    pop      = bus.rd_en & (count_q != '0);
    write_ok = push & (~is_full | pop);
  end

  always_comb begin
    valid_prev_d = bus.valid;
    acc_d        = acc_q;
    n_d          = n_q;
    win_sel_d    = win_sel_q;
    if (accept) begin
      win_sel_d = cur_win;
      if (win_done) begin
        acc_d = '0;
        n_d   = '0;
      end else begin
        acc_d = sum;
        n_d   = n_q + 3'd1;
      end
    end
  end

  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    overflow_d = overflow_q & ~bus.ovf_clr;
    if (write_ok) begin
      mem_d[wr_ptr_q] = avg;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    // Full with a simultaneous pop: same slot is read (old value) and rewritten.
    if (pop) begin
      rd_data_d  = mem_q[rd_ptr_q];
      rd_valid_d = 1'b1;
      rd_ptr_d   = rd_ptr_q + PTR_W'(1);
    end
    if (write_ok && !pop)      count_d = count_q + CNT_W'(1);
    else if (pop && !write_ok) count_d = count_q - CNT_W'(1);
    if (push && is_full && !pop) overflow_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset_in) begin
      valid_prev_q <= 1'b0;
      acc_q        <= '0;
      n_q          <= '0;
      win_sel_q    <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      rd_data_q    <= '0;
      rd_valid_q   <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      valid_prev_q <= valid_prev_d;
      acc_q        <= acc_d;
      n_q          <= n_d;
      win_sel_q    <= win_sel_d;
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      rd_data_q    <= rd_data_d;
      rd_valid_q   <= rd_valid_d;
      overflow_q   <= overflow_d;
    end
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.empty    = count_q == '0;
  assign bus.full     = is_full;
  assign bus.count    = count_q;
  assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_sar_result_buffer.sv
// Bench for sar_result_buffer: directed scenarios plus random traffic, all
// checked against a queue-based model of sampling, averaging and the FIFO.
module tb_sar_result_buffer;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 3;

  logic clk;
  logic reset_in;
  sar_result_buffer_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  sar_result_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .reset_in (reset_in),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Model state: samples of the open window, queued averages, registered read port.
  int m_prev, m_win_len, m_ovf, m_rdata, m_rvalid;
  int win_q[$];
  int fq[$];

  task automatic model_step(input bit v, input int r, input int s, input bit re,
                            input bit oc, input bit rs);
    int sum;
    bit push;
    int pval;
    if (rs) begin
      m_prev = 0; win_q = {}; fq = {}; m_ovf = 0; m_rdata = 0; m_rvalid = 0;
      return;
    end
    push = 0; pval = 0;
    if (v && !m_prev) begin
      if (win_q.size() == 0) m_win_len = 1 << s;
      win_q.push_back(r);
      if (win_q.size() == m_win_len) begin
        sum = 0;
        foreach (win_q[i]) sum += win_q[i];
        pval = sum / m_win_len;
        push = 1;
        win_q = {};
      end
    end
    m_prev = v;
    m_rvalid = 0;
    if (re && fq.size() > 0) begin
      m_rdata  = fq.pop_front();
      m_rvalid = 1;
    end
    if (oc) m_ovf = 0;
    if (push) begin
      if (fq.size() < DEPTH) fq.push_back(pval);
      else m_ovf = 1;
    end
  endtask

  task automatic tick(input bit v, input int r, input int s, input bit re,
                      input bit oc, input bit rs);
    @(negedge clk);
    bus.valid = v; bus.result = DATA_W'(r); bus.avg_sel = 2'(s);
    bus.rd_en = re; bus.ovf_clr = oc; reset_in = rs;
    model_step(v, r, s, re, oc, rs);
    @(posedge clk);
    #1;
    chk("rd_valid", int'(bus.rd_valid), m_rvalid);
    chk("rd_data",  int'(bus.rd_data),  m_rdata);
    chk("count",    int'(bus.count),    fq.size());
    chk("empty",    int'(bus.empty),    int'(fq.size() == 0));
    chk("full",     int'(bus.full),     int'(fq.size() == DEPTH));
    chk("overflow", int'(bus.overflow), m_ovf);
  endtask

  task automatic pulse(input int r, input int s);
    tick(1, r, s, 0, 0, 0);
    tick(0, 0, s, 0, 0, 0);
  endtask

  task automatic rd();
    tick(0, 0, 0, 1, 0, 0);
  endtask

  initial begin
    bus.valid = 0; bus.result = '0; bus.avg_sel = '0; bus.rd_en = 0; bus.ovf_clr = 0;
    reset_in = 1;
    m_prev = 0; m_win_len = 1; m_ovf = 0; m_rdata = 0; m_rvalid = 0;

    tick(0, 0, 0, 0, 0, 1);
    chk("rst_empty", int'(bus.empty), 1);

    // single sample, no averaging
    pulse(8'hA5, 0);
    chk("a5_count", int'(bus.count), 1);
    rd();
    chk("a5_data", int'(bus.rd_data), 8'hA5);
    chk("a5_rvalid", int'(bus.rd_valid), 1);
    chk("a5_empty", int'(bus.empty), 1);
    tick(0, 0, 0, 1, 0, 0);
    chk("rd_empty_ignored", int'(bus.rd_valid), 0);

    // window of four with truncating average
    pulse(10, 2); pulse(11, 2); pulse(12, 2);
    chk("avg4_no_push", int'(bus.count), 0);
    pulse(14, 2);
    chk("avg4_push", int'(bus.count), 1);
    rd();
    chk("avg4_val", int'(bus.rd_data), 11);

    // held-high valid counts once
    for (int i = 0; i < 5; i++) tick(1, 8'h40, 0, 0, 0, 0);
    chk("held_valid", int'(bus.count), 1);
    tick(0, 0, 0, 0, 0, 0);
    rd();

    // fill, overflow, drain, clear
    for (int i = 1; i <= 5; i++) begin
      pulse(i, 0);
      if (i == 4) chk("full_at4", int'(bus.full), 1);
    end
    chk("ovf_at5", int'(bus.overflow), 1);
    for (int i = 1; i <= 4; i++) begin
      rd();
      chk("drain_val", int'(bus.rd_data), i);
    end
    chk("drain_empty", int'(bus.empty), 1);
    tick(0, 0, 0, 0, 1, 0);
    chk("ovf_clr", int'(bus.overflow), 0);

    // push and pop together while full
    for (int i = 0; i < 4; i++) pulse(20 + i, 0);
    tick(1, 99, 0, 1, 0, 0);
    chk("pp_data", int'(bus.rd_data), 20);
    chk("pp_count", int'(bus.count), 4);
    chk("pp_ovf", int'(bus.overflow), 0);
    tick(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) rd();
    chk("pp_last", int'(bus.rd_data), 99);

    // reset mid-window discards the partial sum
    for (int i = 0; i < 5; i++) pulse(8'hF0, 3);
    tick(0, 0, 3, 0, 0, 1);
    for (int i = 0; i < 8; i++) pulse(8'h80, 3);
    chk("rst_win_count", int'(bus.count), 1);
    rd();
    chk("rst_win_val", int'(bus.rd_data), 8'h80);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      tick(bit'($urandom_range(0, 1)), int'($urandom_range(0, 255)),
           int'($urandom_range(0, 3)), bit'($urandom_range(0, 2) == 0),
           bit'($urandom_range(0, 15) == 0), bit'($urandom_range(0, 149) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
